ioctl_loader: RTL

IOCTL_LOADER -- requirements
Module: ioctl_loader

---
 rtl/ioctl_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/ioctl_loader.sv
// HPS ioctl download to memory write bridge: 1-cycle strobe->mem_wr latency, FIFO of DEPTH entries,
// ioctl_wait raised at DEPTH-1 and strobes dropped when full; optional csum output via IOCTL_LOADER_CHECKSUM_EN.
module ioctl_loader #(
    parameter int         DEPTH = 4,
    parameter logic [7:0] INDEX = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        mem_wr,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_data,
    input  logic        mem_ack,
`ifdef IOCTL_LOADER_CHECKSUM_EN
    output logic [15:0] csum,
`endif
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [24:0]    fifo_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [16:0]    byte_cnt_q;
    logic           wait_q, done_q, err_q;
    logic           done_d;
    logic           in_range, full, strobe, push, drop, pop, session_start;

    assign in_range      = (ioctl_addr[24:17] == 8'd0);
    assign full          = (count_q == CW'(DEPTH));
    assign strobe        = (state_q == S_LOAD) && ioctl_wr;
    assign push          = strobe && in_range && !full;
    assign drop          = strobe && (!in_range || full);
    assign pop           = (count_q != '0) && mem_ack;
    assign count_d       = count_q + CW'(push) - CW'(pop);
    assign session_start = (state_q == S_IDLE) && (state_d == S_LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ioctl_download && (ioctl_index == INDEX)) state_d = S_LOAD;
            S_LOAD:  if (!ioctl_download) state_d = S_DRAIN;
            S_DRAIN: if (count_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_LOAD) || (state_q == S_DRAIN);
        done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);
    end

    // Storage carries no reset; the outputs below are gated by the registered count.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {ioctl_addr[16:0], ioctl_dout};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            wait_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            wait_q  <= (count_d >= CW'(DEPTH - 1));
            done_q  <= done_d;
            if (session_start)  byte_cnt_q <= '0;
            else if (push)      byte_cnt_q <= byte_cnt_q + 17'd1;
            if (session_start)  err_q <= 1'b0;
            else if (drop)      err_q <= 1'b1;
        end
    end

`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              csum_q <= '0;
        else if (session_start) csum_q <= '0;
        else if (push)          csum_q <= csum_q + {8'd0, ioctl_dout};
    end

    assign csum = csum_q;
`endif

    assign mem_wr                = (count_q != '0);
    assign {mem_addr, mem_data}  = mem_wr ? fifo_q[rd_ptr_q] : 25'd0;
    assign ioctl_wait            = wait_q;
    assign done                  = done_q;
    assign err                   = err_q;
endmodule
